// File: rtl/bus_arbiter.sv
// Time-slot arbiter sharing the PET RAM/IO bus between the 6502 CPU and the Pi SPI bridge.
// Each frame of 2^FRAME_BITS cycles holds a CPU half followed by an optional Pi half.
module bus_arbiter #(
  parameter int FRAME_BITS = 4
) (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic [16:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_data_out,
  input  logic        i_cpu_rw_b,
  output logic [7:0]  o_cpu_data_in,
  output logic        o_cpu_en,
  input  logic [16:0] i_pi_addr,
  input  logic [7:0]  i_pi_data_out,
  input  logic        i_pi_rw_b,
  input  logic        i_pi_pending,
  output logic        o_pi_done,
  output logic [7:0]  o_pi_data_in,
  output logic [16:0] o_ram_addr,
  output logic [7:0]  o_ram_data_out,
  input  logic [7:0]  i_ram_data_in,
  output logic        o_ram_we_n,
  output logic        o_ram_oe_n,
  output logic [1:0]  o_state
);

  localparam int N = 2 ** FRAME_BITS;
  localparam int H = N / 2;
  localparam logic [FRAME_BITS-1:0] CNT_ONE     = FRAME_BITS'(1);
  localparam logic [FRAME_BITS-1:0] CNT_LAST    = FRAME_BITS'(N - 1);
  localparam logic [FRAME_BITS-1:0] CNT_HALF_M1 = FRAME_BITS'(H - 1);
  localparam logic [FRAME_BITS-2:0] K_WR_FIRST  = (FRAME_BITS-1)'(1);
  localparam logic [FRAME_BITS-2:0] K_WR_LAST   = (FRAME_BITS-1)'(H - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_PI   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FRAME_BITS-1:0] r_cnt;
  logic [FRAME_BITS-1:0] w_cnt_nxt;
  logic [FRAME_BITS-2:0] w_k_nxt;
  logic                  r_first;
  logic                  r_rw;
  logic                  w_rw_nxt;
  logic [16:0]           r_addr;
  logic [16:0]           w_addr_nxt;
  logic [7:0]            r_wdata;
  logic [7:0]            w_wdata_nxt;
  logic                  r_oe_n;
  logic                  w_oe_n_nxt;
  logic                  r_we_n;
  logic                  w_we_n_nxt;
  logic                  r_cpu_en;
  logic                  w_cpu_en_nxt;
  logic                  r_pi_done;
  logic                  w_pi_done_nxt;
  logic [7:0]            r_cpu_rdata;
  logic [7:0]            w_cpu_rdata_nxt;
  logic [7:0]            r_pi_rdata;
  logic [7:0]            w_pi_rdata_nxt;
  logic                  w_wrap;
  logic                  w_half;
  logic                  w_slot_nxt;

  assign w_wrap = (r_cnt == CNT_LAST);
  assign w_half = (r_cnt == CNT_HALF_M1);

  // State register
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, slot latching and next values of every registered output
  always_comb begin
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_state_nxt = r_state;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;

    if (w_wrap) begin
      w_state_nxt = ST_CPU;
      w_rw_nxt    = i_cpu_rw_b;
      w_addr_nxt  = i_cpu_addr;
      w_wdata_nxt = i_cpu_data_out;
    end else if (w_half) begin
      // No Pi slot in the frame right after reset, nor while a completed transfer is still acknowledged
      if (i_pi_pending && !r_pi_done && !r_first) begin
        w_state_nxt = ST_PI;
        w_rw_nxt    = i_pi_rw_b;
        w_addr_nxt  = i_pi_addr;
        w_wdata_nxt = i_pi_data_out;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      w_state_nxt = r_state;
    end

    // Slot offset is the low counter bits for both halves
    w_k_nxt    = w_cnt_nxt[FRAME_BITS-2:0];
    w_slot_nxt = (w_state_nxt != ST_IDLE);
    w_oe_n_nxt = !(w_slot_nxt && w_rw_nxt);
    w_we_n_nxt = !(w_slot_nxt && !w_rw_nxt &&
                   (w_k_nxt >= K_WR_FIRST) && (w_k_nxt <= K_WR_LAST));

    w_cpu_en_nxt = (w_cnt_nxt == CNT_LAST) && !r_first;

    w_cpu_rdata_nxt = r_cpu_rdata;
    w_pi_rdata_nxt  = r_pi_rdata;
    case (r_state)
      ST_CPU: begin
        if (r_rw && w_half) begin
          w_cpu_rdata_nxt = i_ram_data_in;
        end else begin
          w_cpu_rdata_nxt = r_cpu_rdata;
        end
      end
      ST_PI: begin
        if (r_rw && w_wrap) begin
          w_pi_rdata_nxt = i_ram_data_in;
        end else begin
          w_pi_rdata_nxt = r_pi_rdata;
        end
      end
      default: begin
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_pi_rdata_nxt  = r_pi_rdata;
      end
    endcase

    if (!i_pi_pending) begin
      w_pi_done_nxt = 1'b0;
    end else if ((r_state == ST_PI) && w_wrap) begin
      w_pi_done_nxt = 1'b1;
    end else begin
      w_pi_done_nxt = r_pi_done;
    end
  end

  // Frame counter, latched bus fields and registered outputs
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_rw        <= 1'b1;
      r_addr      <= 17'd0;
      r_wdata     <= 8'd0;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_cpu_en    <= 1'b0;
      r_pi_done   <= 1'b0;
      r_cpu_rdata <= 8'd0;
      r_pi_rdata  <= 8'd0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_first     <= r_first && !w_wrap;
      r_rw        <= w_rw_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_we_n      <= w_we_n_nxt;
      r_cpu_en    <= w_cpu_en_nxt;
      r_pi_done   <= w_pi_done_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_pi_rdata  <= w_pi_rdata_nxt;
    end
  end

  assign o_state        = r_state;
  assign o_ram_addr     = r_addr;
  assign o_ram_data_out = r_wdata;
  assign o_ram_oe_n     = r_oe_n;
  assign o_ram_we_n     = r_we_n;
  assign o_cpu_en       = r_cpu_en;
  assign o_pi_done      = r_pi_done;
  assign o_cpu_data_in  = r_cpu_rdata;
  assign o_pi_data_in   = r_pi_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expectations are queued against absolute cycle numbers
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_bus_arbiter;

  localparam int S_ADDR  = 0;
  localparam int S_WDATA = 1;
  localparam int S_OE    = 2;
  localparam int S_WE    = 3;
  localparam int S_CPUEN = 4;
  localparam int S_DONE  = 5;
  localparam int S_CPUD  = 6;
  localparam int S_PID   = 7;
  localparam int S_STATE = 8;

  logic        clk;
  logic        rst;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_rw_b;
  logic [7:0]  cpu_data_in;
  logic        cpu_en;
  logic [16:0] pi_addr;
  logic [7:0]  pi_data_out;
  logic        pi_rw_b;
  logic        pi_pending;
  logic        pi_done;
  logic [7:0]  pi_data_in;
  logic [16:0] ram_addr;
  logic [7:0]  ram_data_out;
  logic [7:0]  ram_data_in;
  logic        ram_we_n;
  logic        ram_oe_n;
  logic [1:0]  state;

  typedef struct {
    int          c;
    int          sig;
    logic [16:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   c0 = 0;
  int   r0 = 0;
  bit   end_req = 1'b0;
  bit   end_done = 1'b0;

  bus_arbiter #(.FRAME_BITS(4)) dut (
    .i_sys_clk      (clk),
    .i_reset        (rst),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_data_out (cpu_data_out),
    .i_cpu_rw_b     (cpu_rw_b),
    .o_cpu_data_in  (cpu_data_in),
    .o_cpu_en       (cpu_en),
    .i_pi_addr      (pi_addr),
    .i_pi_data_out  (pi_data_out),
    .i_pi_rw_b      (pi_rw_b),
    .i_pi_pending   (pi_pending),
    .o_pi_done      (pi_done),
    .o_pi_data_in   (pi_data_in),
    .o_ram_addr     (ram_addr),
    .o_ram_data_out (ram_data_out),
    .i_ram_data_in  (ram_data_in),
    .o_ram_we_n     (ram_we_n),
    .o_ram_oe_n     (ram_oe_n),
    .o_state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] sig_val(int s);
    case (s)
      S_ADDR:  return ram_addr;
      S_WDATA: return {9'd0, ram_data_out};
      S_OE:    return {16'd0, ram_oe_n};
      S_WE:    return {16'd0, ram_we_n};
      S_CPUEN: return {16'd0, cpu_en};
      S_DONE:  return {16'd0, pi_done};
      S_CPUD:  return {9'd0, cpu_data_in};
      S_PID:   return {9'd0, pi_data_in};
      S_STATE: return {15'd0, state};
      default: return 17'h1FFFF;
    endcase
  endfunction

  // absolute cycle of counter value k in frame f (frame 1 starts at c0)
  function automatic int fr(int f, int k);
    return c0 + 16 * (f - 1) + k;
  endfunction

  task automatic expect_at(input int c, input int s, input logic [16:0] v, input string nm);
    exp_t e;
    int   pos;
    e.c = c; e.sig = s; e.v = v; e.nm = nm;
    pos = sb.size();
    for (int j = 0; j < sb.size(); j++) begin
      if (sb[j].c > c) begin
        pos = j;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic expect_reset_vals(input int c);
    expect_at(c, S_ADDR,  17'd0, "rst_ram_addr");
    expect_at(c, S_WDATA, 17'd0, "rst_ram_data_out");
    expect_at(c, S_OE,    17'd1, "rst_oe_n");
    expect_at(c, S_WE,    17'd1, "rst_we_n");
    expect_at(c, S_CPUEN, 17'd0, "rst_cpu_en");
    expect_at(c, S_DONE,  17'd0, "rst_pi_done");
    expect_at(c, S_CPUD,  17'd0, "rst_cpu_data_in");
    expect_at(c, S_PID,   17'd0, "rst_pi_data_in");
    expect_at(c, S_STATE, 17'd0, "rst_state");
  endtask

  // go to 1 ns after the negedge of absolute cycle t
  task automatic wait_cyc(input int t);
    do @(negedge clk); while (cyc < t);
    #1;
  endtask

  // Monitor: strobe exclusivity every cycle, then all expectations due this cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] act;
    checks++;
    if (!ram_oe_n && !ram_we_n) begin
      failures++;
      $display("FAIL strobe_overlap @cyc %0d: oe_n=%0b we_n=%0b, required not both 0", cyc, ram_oe_n, ram_we_n);
    end
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      checks++;
      act = sig_val(e.sig);
      if (e.c < cyc) begin
        failures++;
        $display("FAIL %s stale expectation for cyc %0d seen at cyc %0d", e.nm, e.c, cyc);
      end else if (act !== e.v) begin
        failures++;
        $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", e.nm, cyc, act, e.v);
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      end_done = 1'b1;
    end
  end

  initial begin
    rst = 1'b1;
    cpu_addr = 17'h01234; cpu_data_out = 8'h77; cpu_rw_b = 1'b1;
    pi_addr = 17'd0; pi_data_out = 8'd0; pi_rw_b = 1'b1; pi_pending = 1'b0;
    ram_data_in = 8'hA5;
    expect_reset_vals(1);

    wait_cyc(2);
    rst = 1'b0;
    c0 = cyc;

    // frame 1: nothing happens, no cpu_en
    expect_at(fr(1, 1),  S_OE,    17'd1, "f1_oe_idle");
    expect_at(fr(1, 9),  S_STATE, 17'd0, "f1_state_idle");
    expect_at(fr(1, 15), S_CPUEN, 17'd0, "f1_no_cpu_en");
    // frame 2: CPU read of 0x01234 returning 0xA5
    for (int k = 0; k < 8; k++) expect_at(fr(2, k), S_OE, 17'd0, "cpu_rd_oe_low");
    expect_at(fr(2, 0),  S_ADDR,  17'h01234, "cpu_rd_addr_k0");
    expect_at(fr(2, 7),  S_ADDR,  17'h01234, "cpu_rd_addr_k7");
    expect_at(fr(2, 0),  S_WDATA, 17'h00077, "cpu_wdata_latched");
    expect_at(fr(2, 3),  S_WE,    17'd1, "cpu_rd_we_high");
    expect_at(fr(2, 3),  S_STATE, 17'd1, "cpu_state");
    expect_at(fr(2, 7),  S_CPUD,  17'h00000, "cpu_rd_before_capture");
    expect_at(fr(2, 8),  S_CPUD,  17'h000A5, "cpu_rd_capture");
    expect_at(fr(2, 8),  S_OE,    17'd1, "cpu_rd_oe_end");
    expect_at(fr(2, 8),  S_STATE, 17'd0, "idle_after_cpu");
    expect_at(fr(2, 14), S_CPUEN, 17'd0, "cpu_en_k14");
    expect_at(fr(2, 15), S_CPUEN, 17'd1, "cpu_en_k15");

    // frame 3: Pi write raised at cnt=7
    wait_cyc(fr(3, 7));
    pi_pending = 1'b1; pi_rw_b = 1'b0; pi_addr = 17'h18000; pi_data_out = 8'h3C;
    expect_at(fr(3, 8),  S_STATE, 17'd2, "pi_wr_state");
    expect_at(fr(3, 8),  S_ADDR,  17'h18000, "pi_wr_addr_k8");
    expect_at(fr(3, 15), S_ADDR,  17'h18000, "pi_wr_addr_k15");
    expect_at(fr(3, 8),  S_WDATA, 17'h0003C, "pi_wr_data_k8");
    expect_at(fr(3, 15), S_WDATA, 17'h0003C, "pi_wr_data_k15");
    expect_at(fr(3, 8),  S_WE,    17'd1, "pi_wr_setup");
    expect_at(fr(3, 9),  S_WE,    17'd0, "pi_wr_we_k9");
    expect_at(fr(3, 14), S_WE,    17'd0, "pi_wr_we_k14");
    expect_at(fr(3, 15), S_WE,    17'd1, "pi_wr_hold");
    expect_at(fr(3, 10), S_OE,    17'd1, "pi_wr_oe_high");
    expect_at(fr(3, 15), S_DONE,  17'd0, "pi_wr_done_early");
    expect_at(fr(4, 0),  S_DONE,  17'd1, "pi_wr_done_9cyc");
    expect_at(fr(4, 0),  S_ADDR,  17'h01234, "cpu_addr_after_pi");
    expect_at(fr(4, 0),  S_WDATA, 17'h00077, "cpu_wdata_after_pi");
    // frames 4..6: pending held, no new slot
    for (int f = 4; f <= 6; f++) begin
      expect_at(fr(f, 8),  S_STATE, 17'd0, "held_no_pi_slot");
      expect_at(fr(f, 9),  S_WE,    17'd1, "held_no_we");
      expect_at(fr(f, 8),  S_DONE,  17'd1, "held_done_k8");
      expect_at(fr(f, 15), S_DONE,  17'd1, "held_done_k15");
    end
    expect_at(fr(5, 12), S_ADDR, 17'h01234, "idle_addr_hold");
    expect_at(fr(7, 2),  S_DONE, 17'd1, "held_done_f7");

    wait_cyc(fr(7, 2));
    pi_pending = 1'b0;
    expect_at(fr(7, 3), S_DONE, 17'd0, "done_clear_one_edge");

    wait_cyc(fr(7, 5));
    pi_pending = 1'b1; pi_rw_b = 1'b0; pi_addr = 17'h00ABC; pi_data_out = 8'h11;
    expect_at(fr(7, 8),  S_STATE, 17'd2, "rearm_state");
    expect_at(fr(7, 8),  S_ADDR,  17'h00ABC, "rearm_addr");
    expect_at(fr(7, 9),  S_WDATA, 17'h00011, "rearm_wdata");
    expect_at(fr(7, 9),  S_WE,    17'd0, "rearm_we");
    expect_at(fr(7, 15), S_DONE,  17'd0, "rearm_done_early");
    expect_at(fr(8, 0),  S_DONE,  17'd1, "rearm_done");

    wait_cyc(fr(8, 1));
    pi_pending = 1'b0;
    expect_at(fr(8, 2), S_DONE, 17'd0, "rearm_done_clear");

    // frame 9: Pi read raised at cnt=8 waits for the next frame
    wait_cyc(fr(9, 8));
    pi_pending = 1'b1; pi_rw_b = 1'b1; pi_addr = 17'h00100; ram_data_in = 8'h5A;
    expect_at(fr(9, 9),   S_STATE, 17'd0, "late_rd_no_slot");
    expect_at(fr(9, 10),  S_OE,    17'd1, "late_rd_no_oe");
    expect_at(fr(9, 15),  S_DONE,  17'd0, "late_rd_done_f9");
    expect_at(fr(10, 8),  S_CPUD,  17'h0005A, "cpu_rd_5a");
    expect_at(fr(10, 8),  S_STATE, 17'd2, "late_rd_state");
    expect_at(fr(10, 8),  S_ADDR,  17'h00100, "late_rd_addr");
    expect_at(fr(10, 8),  S_OE,    17'd0, "late_rd_oe_k8");
    expect_at(fr(10, 15), S_OE,    17'd0, "late_rd_oe_k15");
    expect_at(fr(10, 12), S_WE,    17'd1, "late_rd_we_high");
    expect_at(fr(10, 15), S_PID,   17'h00000, "late_rd_pid_before");
    expect_at(fr(10, 15), S_DONE,  17'd0, "late_rd_done_early");
    expect_at(fr(11, 0),  S_PID,   17'h0005A, "late_rd_pid");
    expect_at(fr(11, 0),  S_DONE,  17'd1, "late_rd_done_24cyc");

    wait_cyc(fr(11, 1));
    pi_pending = 1'b0;
    expect_at(fr(11, 2), S_DONE, 17'd0, "late_rd_done_clear");

    // frame 12: Pi read with pending dropped at cnt=10
    wait_cyc(fr(12, 3));
    pi_pending = 1'b1; pi_rw_b = 1'b1; pi_addr = 17'h1FFFF; ram_data_in = 8'hC3;
    expect_at(fr(12, 8),  S_STATE, 17'd2, "drop_state");
    expect_at(fr(12, 8),  S_PID,   17'h0005A, "drop_pid_before");

    wait_cyc(fr(12, 10));
    pi_pending = 1'b0;
    expect_at(fr(12, 11), S_OE,    17'd0, "drop_oe_k11");
    expect_at(fr(12, 15), S_OE,    17'd0, "drop_oe_k15");
    expect_at(fr(12, 15), S_ADDR,  17'h1FFFF, "drop_addr");
    expect_at(fr(12, 15), S_STATE, 17'd2, "drop_state_k15");
    expect_at(fr(12, 11), S_DONE,  17'd0, "drop_done_k11");
    expect_at(fr(13, 0),  S_DONE,  17'd0, "drop_done_k0");
    expect_at(fr(13, 1),  S_DONE,  17'd0, "drop_done_k1");
    expect_at(fr(13, 0),  S_PID,   17'h000C3, "drop_pid");

    // frame 14: CPU write
    wait_cyc(fr(13, 2));
    cpu_rw_b = 1'b0; cpu_addr = 17'h0BEEF; cpu_data_out = 8'h99;
    expect_at(fr(13, 8), S_CPUD, 17'h000C3, "cpu_rd_c3");

    wait_cyc(fr(13, 9));
    ram_data_in = 8'hEE;
    expect_at(fr(14, 0),  S_WE,    17'd1, "cpu_wr_setup");
    expect_at(fr(14, 1),  S_WE,    17'd0, "cpu_wr_we_k1");
    expect_at(fr(14, 6),  S_WE,    17'd0, "cpu_wr_we_k6");
    expect_at(fr(14, 7),  S_WE,    17'd1, "cpu_wr_hold");
    expect_at(fr(14, 3),  S_OE,    17'd1, "cpu_wr_oe_high");
    expect_at(fr(14, 3),  S_ADDR,  17'h0BEEF, "cpu_wr_addr");
    expect_at(fr(14, 3),  S_WDATA, 17'h00099, "cpu_wr_data");
    expect_at(fr(14, 8),  S_CPUD,  17'h000C3, "cpu_wr_no_capture");
    expect_at(fr(14, 15), S_CPUEN, 17'd1, "cpu_wr_cpu_en");

    wait_cyc(fr(14, 9));
    cpu_rw_b = 1'b1; cpu_addr = 17'h01234;
    expect_at(fr(15, 8), S_CPUD, 17'h000EE, "cpu_rd_ee");

    // frame 15: Pi write interrupted by reset at cnt=11
    wait_cyc(fr(15, 2));
    pi_pending = 1'b1; pi_rw_b = 1'b0; pi_addr = 17'h12345; pi_data_out = 8'h55;
    expect_at(fr(15, 9),  S_WE,    17'd0, "rst_pi_we_k9");
    expect_at(fr(15, 10), S_WE,    17'd0, "rst_pi_we_k10");
    expect_at(fr(15, 10), S_ADDR,  17'h12345, "rst_pi_addr");
    expect_at(fr(15, 10), S_STATE, 17'd2, "rst_pi_state");

    wait_cyc(fr(15, 10));
    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_reset_vals(cyc);

    wait_cyc(fr(15, 12));
    rst = 1'b0;
    r0 = cyc;
    for (int k = 1; k < 16; k++) begin
      expect_at(r0 + k, S_OE, 17'd1, "post_rst_oe_quiet");
      expect_at(r0 + k, S_WE, 17'd1, "post_rst_we_quiet");
    end
    expect_at(r0 + 8,  S_STATE, 17'd0, "post_rst_no_pi");
    expect_at(r0 + 15, S_CPUEN, 17'd0, "post_rst_no_cpu_en");
    expect_at(r0 + 15, S_DONE,  17'd0, "post_rst_done");
    expect_at(r0 + 16, S_STATE, 17'd1, "post_rst_cpu_slot");
    expect_at(r0 + 16, S_OE,    17'd0, "post_rst_first_oe");
    expect_at(r0 + 16, S_ADDR,  17'h01234, "post_rst_cpu_addr");
    expect_at(r0 + 24, S_STATE, 17'd2, "post_rst_pi_slot");
    expect_at(r0 + 24, S_ADDR,  17'h12345, "post_rst_pi_addr");
    expect_at(r0 + 24, S_WDATA, 17'h00055, "post_rst_pi_data");
    expect_at(r0 + 25, S_WE,    17'd0, "post_rst_pi_we");
    expect_at(r0 + 32, S_DONE,  17'd1, "post_rst_pi_done");

    wait_cyc(r0 + 33);
    pi_pending = 1'b0;
    wait_cyc(r0 + 36);
    end_req = 1'b1;
    wait_cyc(r0 + 38);
    if (!end_done) begin
      failures++;
      $display("FAIL scoreboard_drain_not_reached: end_done=%0b, expected 1", end_done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
